// File: rtl/reaction_timer.sv
// reaction_timer: core timing engine of the reaction game.
// Synchronizes the 500 Hz tick and the player buttons into the clk domain, runs
// one round (random hold-off, GO light, reaction measurement) and reports the
// reaction time in milliseconds as four BCD digits.
// Optional feature: define REACTION_FOUL_EN to turn a press during the
// hold-off into a false start (FOUL state); otherwise such presses are ignored.

module reaction_timer #(
   parameter int unsigned WAIT_MIN_TICKS  = 500,  // minimum hold-off, 2 ms ticks
   parameter int unsigned WAIT_STEP_TICKS = 4     // ticks added per LFSR unit
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tick_i,
   input  logic        start_btn_i,
   input  logic        react_btn_i,
   output logic        led_go_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        foul_o,
   output logic        timeout_o,
   output logic [15:0] time_bcd_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_GO,
      S_DONE,
      S_FOUL
   } state_t;

   localparam logic [15:0] WAIT_MIN_W  = 16'(WAIT_MIN_TICKS);
   localparam logic [15:0] WAIT_STEP_W = 16'(WAIT_STEP_TICKS);
   localparam logic [15:0] BCD_LAST    = 16'h9998;
   localparam logic [15:0] BCD_SAT     = 16'h9999;

   // Synchronizer chains, previous-level flops and registered edge pulses.
   logic [1:0]  tick_sync_q, start_sync_q, react_sync_q;
   logic        tick_prev_q, start_prev_q, react_prev_q;
   logic        tick_q, start_q, react_q;

   logic [7:0]  lfsr_q;
   state_t      state_q;
   logic [15:0] wait_cnt_q;
   logic [15:0] time_bcd_q;
   logic        led_go_q, busy_q, done_q, foul_q, timeout_q;

   logic [15:0] wait_load_d;
   logic [15:0] time_bcd_d;

   // Adds 2 ms to a 4-digit BCD value, rippling a decimal carry digit by digit.
   function automatic logic [15:0] bcd_add2(input logic [15:0] v);
      logic [15:0] r;
      logic [4:0]  s;
      logic [4:0]  add;
      // NOTE: blocking assignments are right here: r, s and add are scratch
      // values evaluated in order within one call, not clocked state.
      r   = v;
      add = 5'd2;
      for (int i = 0; i < 4; i++) begin
         s = {1'b0, v[i*4 +: 4]} + add;
         if (s > 5'd9) begin
            s   = s - 5'd10;
            add = 5'd1;
         end else begin
            add = 5'd0;
         end
         r[i*4 +: 4] = s[3:0];
      end
      return r;
   endfunction

   assign wait_load_d = WAIT_MIN_W + 16'(lfsr_q) * WAIT_STEP_W;
   assign time_bcd_d  = bcd_add2(time_bcd_q);

   // Two-flop synchronizers plus a registered rising-edge detector per input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_sync_q  <= '0;
         start_sync_q <= '0;
         react_sync_q <= '0;
         tick_prev_q  <= 1'b0;
         start_prev_q <= 1'b0;
         react_prev_q <= 1'b0;
         tick_q       <= 1'b0;
         start_q      <= 1'b0;
         react_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every flop sample the value
         // from before this edge, which is what turns this into a shift chain.
         tick_sync_q  <= {tick_sync_q[0], tick_i};
         start_sync_q <= {start_sync_q[0], start_btn_i};
         react_sync_q <= {react_sync_q[0], react_btn_i};
         tick_prev_q  <= tick_sync_q[1];
         start_prev_q <= start_sync_q[1];
         react_prev_q <= react_sync_q[1];
         tick_q       <= tick_sync_q[1]  & ~tick_prev_q;
         start_q      <= start_sync_q[1] & ~start_prev_q;
         react_q      <= react_sync_q[1] & ~react_prev_q;
      end
   end

   // Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1); nonzero seed keeps it off zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= 8'h01;
      end else begin
         lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      end
   end

   // Round state machine with all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         wait_cnt_q <= '0;
         time_bcd_q <= '0;
         led_go_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         foul_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE, S_FOUL: begin
               // A start always begins a fresh round, even on a react in the same cycle.
               if (start_q) begin
                  state_q    <= S_WAIT;
                  wait_cnt_q <= wait_load_d;
                  time_bcd_q <= '0;
                  timeout_q  <= 1'b0;
                  foul_q     <= 1'b0;
                  led_go_q   <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            S_WAIT: begin
`ifdef REACTION_FOUL_EN
               if (react_q) begin
                  state_q    <= S_FOUL;
                  foul_q     <= 1'b1;
                  busy_q     <= 1'b0;
                  led_go_q   <= 1'b0;
                  time_bcd_q <= '0;
               end else
`endif
               if (tick_q) begin
                  if (wait_cnt_q == 16'd1) begin
                     state_q  <= S_GO;
                     led_go_q <= 1'b1;
                  end else begin
                     wait_cnt_q <= wait_cnt_q - 16'd1;
                  end
               end
            end
            S_GO: begin
               // React beats a coincident tick, so that tick is never counted.
               if (react_q) begin
                  state_q  <= S_DONE;
                  done_q   <= 1'b1;
                  led_go_q <= 1'b0;
                  busy_q   <= 1'b0;
               end else if (tick_q) begin
                  if (time_bcd_q == BCD_LAST) begin
                     state_q    <= S_DONE;
                     time_bcd_q <= BCD_SAT;
                     timeout_q  <= 1'b1;
                     done_q     <= 1'b1;
                     led_go_q   <= 1'b0;
                     busy_q     <= 1'b0;
                  end else begin
                     time_bcd_q <= time_bcd_d;
                  end
               end
            end
            default: begin
               state_q  <= S_IDLE;
               led_go_q <= 1'b0;
               busy_q   <= 1'b0;
               foul_q   <= 1'b0;
            end
         endcase
      end
   end

   assign led_go_o   = led_go_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign foul_o     = foul_q;
   assign timeout_o  = timeout_q;
   assign time_bcd_o = time_bcd_q;

endmodule

// File: tb/tb_reaction_timer.sv
// tb_reaction_timer: two reaction_timer instances (fixed hold-off and
// LFSR-scaled hold-off) driven by shared pins and checked every cycle against
// a behavioural model that keeps the reaction time as an integer of ms.

module tb_reaction_timer;

   localparam int MIN0 = 3, STEP0 = 0;
   localparam int MIN1 = 2, STEP1 = 1;
`ifdef REACTION_FOUL_EN
   localparam bit FOUL_EN = 1'b1;
`else
   localparam bit FOUL_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic tick_i = 1'b0, start_btn_i = 1'b0, react_btn_i = 1'b0;
   logic        led_go_o [2];
   logic        busy_o [2];
   logic        done_o [2];
   logic        foul_o [2];
   logic        timeout_o [2];
   logic [15:0] time_bcd_o [2];

   int n_tests = 0;
   int n_fail  = 0;
   int done_cnt = 0;

   always #5 clk = ~clk;

   reaction_timer #(.WAIT_MIN_TICKS(MIN0), .WAIT_STEP_TICKS(STEP0)) dut (
      .clk(clk), .rst_n(rst_n), .tick_i(tick_i), .start_btn_i(start_btn_i),
      .react_btn_i(react_btn_i), .led_go_o(led_go_o[0]), .busy_o(busy_o[0]),
      .done_o(done_o[0]), .foul_o(foul_o[0]), .timeout_o(timeout_o[0]),
      .time_bcd_o(time_bcd_o[0]));

   reaction_timer #(.WAIT_MIN_TICKS(MIN1), .WAIT_STEP_TICKS(STEP1)) dut_rnd (
      .clk(clk), .rst_n(rst_n), .tick_i(tick_i), .start_btn_i(start_btn_i),
      .react_btn_i(react_btn_i), .led_go_o(led_go_o[1]), .busy_o(busy_o[1]),
      .done_o(done_o[1]), .foul_o(foul_o[1]), .timeout_o(timeout_o[1]),
      .time_bcd_o(time_bcd_o[1]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef enum {M_IDLE, M_WAIT, M_GO, M_DONE, M_FOUL} mstate_t;
   mstate_t  m_state [2];
   int       m_target [2];   // ticks the hold-off lasts
   int       m_seen [2];     // ticks seen so far in the hold-off
   int       m_ms [2];       // measured time in ms
   bit       m_timeout [2];
   bit       m_done [2];
   bit [7:0] m_lfsr;
   bit [3:0] h_tick, h_start, h_react;   // pin samples, [0] = previous edge

   function automatic logic [15:0] to_bcd(input int ms);
      return {4'(ms / 1000 % 10), 4'(ms / 100 % 10), 4'(ms / 10 % 10), 4'(ms % 10)};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_state[i] = M_IDLE; m_target[i] = 0; m_seen[i] = 0;
         m_ms[i] = 0; m_timeout[i] = 1'b0; m_done[i] = 1'b0;
      end
      m_lfsr = 8'h01;
      h_tick = '0; h_start = '0; h_react = '0;
   endtask

   task automatic model_step(input int i, input bit tk, input bit st, input bit rc);
      m_done[i] = 1'b0;
      case (m_state[i])
         M_IDLE, M_DONE, M_FOUL: begin
            if (st) begin
               m_state[i]   = M_WAIT;
               m_target[i]  = (i == 0) ? MIN0 + int'(m_lfsr) * STEP0 : MIN1 + int'(m_lfsr) * STEP1;
               m_seen[i]    = 0;
               m_ms[i]      = 0;
               m_timeout[i] = 1'b0;
            end
         end
         M_WAIT: begin
            if (rc && FOUL_EN) begin
               m_state[i] = M_FOUL;
               m_ms[i]    = 0;
            end else if (tk) begin
               m_seen[i]++;
               if (m_seen[i] == m_target[i]) m_state[i] = M_GO;
            end
         end
         M_GO: begin
            if (rc) begin
               m_state[i] = M_DONE;
               m_done[i]  = 1'b1;
            end else if (tk) begin
               if (m_ms[i] + 2 > 9998) begin
                  m_ms[i] = 9999; m_timeout[i] = 1'b1;
                  m_done[i] = 1'b1; m_state[i] = M_DONE;
               end else begin
                  m_ms[i] += 2;
               end
            end
         end
         default: m_state[i] = M_IDLE;
      endcase
   endtask

   // An input edge sampled at edge n acts at edge n+3.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         model_reset();
      end else begin
         for (int i = 0; i < 2; i++)
            model_step(i, h_tick[2] & ~h_tick[3], h_start[2] & ~h_start[3], h_react[2] & ~h_react[3]);
         m_lfsr  = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
         h_tick  = {h_tick[2:0], tick_i};
         h_start = {h_start[2:0], start_btn_i};
         h_react = {h_react[2:0], react_btn_i};
      end
   end

   function automatic logic [20:0] pack_act(input int i);
      return {led_go_o[i], busy_o[i], done_o[i], foul_o[i], timeout_o[i], time_bcd_o[i]};
   endfunction

   function automatic logic [20:0] pack_exp(input int i);
      return {m_state[i] == M_GO, (m_state[i] == M_WAIT) || (m_state[i] == M_GO),
              m_done[i], m_state[i] == M_FOUL, m_timeout[i], to_bcd(m_ms[i])};
   endfunction

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 2; i++)
            check($sformatf("cycle_dut%0d", i), 32'(pack_act(i)), 32'(pack_exp(i)));
         if (done_o[0]) done_cnt++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         tick_i = 1'b1; cyc(3);
         tick_i = 1'b0; cyc(3);
      end
   endtask

   task automatic press_start();
      start_btn_i = 1'b1; cyc(3);
      start_btn_i = 1'b0; cyc(3);
   endtask

   task automatic press_react();
      react_btn_i = 1'b1; cyc(3);
      react_btn_i = 1'b0; cyc(3);
   endtask

   initial begin
      int d0;
      cyc(3);
      rst_n = 1'b1;
      cyc(5);
      check("idle_outputs", 32'(pack_act(0)), 32'd0);

      // Normal round: hold-off of 3 ticks, 5 ticks in GO -> 10 ms.
      press_start();
      check("wait_busy", 32'(busy_o[0]), 32'd1);
      ticks(2);
      check("wait_led_off", 32'(led_go_o[0]), 32'd0);
      ticks(1);
      check("go_led_on", 32'(led_go_o[0]), 32'd1);
      d0 = done_cnt;
      ticks(5);
      press_react();
      check("normal_bcd", 32'(time_bcd_o[0]), 32'h0010);
      check("normal_led_off", 32'(led_go_o[0]), 32'd0);
      check("normal_done_pulses", 32'(done_cnt - d0), 32'd1);

      // BCD carries into hundreds and thousands.
      press_start(); ticks(3 + 50); press_react();
      check("carry_100", 32'(time_bcd_o[0]), 32'h0100);
      press_start(); ticks(3 + 500); press_react();
      check("carry_1000", 32'(time_bcd_o[0]), 32'h1000);

      // Saturation at 9999 ms.
      press_start(); ticks(3 + 4999);
      check("sat_9998", 32'(time_bcd_o[0]), 32'h9998);
      check("sat_no_timeout_yet", 32'(timeout_o[0]), 32'd0);
      d0 = done_cnt;
      ticks(1);
      check("sat_9999", 32'(time_bcd_o[0]), 32'h9999);
      check("sat_timeout", 32'(timeout_o[0]), 32'd1);
      check("sat_done_pulses", 32'(done_cnt - d0), 32'd1);
      check("sat_idle", 32'(busy_o[0]), 32'd0);

      // False start during the hold-off.
      press_start(); ticks(1); press_react();
`ifdef REACTION_FOUL_EN
      check("foul_flag", 32'(foul_o[0]), 32'd1);
      check("foul_busy", 32'(busy_o[0]), 32'd0);
      ticks(2);
      check("foul_no_go", 32'(led_go_o[0]), 32'd0);
`else
      check("nofoul_still_wait", 32'(busy_o[0]), 32'd1);
      check("nofoul_flag", 32'(foul_o[0]), 32'd0);
      ticks(2);
      check("nofoul_go", 32'(led_go_o[0]), 32'd1);
      press_react();
`endif

      // Tie: react and tick edges together at 8 ms -> react wins.
      press_start(); ticks(3 + 4);
      check("tie_pre", 32'(time_bcd_o[0]), 32'h0008);
      tick_i = 1'b1; react_btn_i = 1'b1; cyc(3);
      tick_i = 1'b0; react_btn_i = 1'b0; cyc(3);
      check("tie_bcd", 32'(time_bcd_o[0]), 32'h0008);
      check("tie_done_state", 32'(busy_o[0]), 32'd0);
      press_start();
      check("restart_busy", 32'(busy_o[0]), 32'd1);
      check("restart_bcd", 32'(time_bcd_o[0]), 32'h0000);

      // Asynchronous reset in the middle of GO.
      ticks(3 + 2);
      check("pre_reset_go", 32'(led_go_o[0]), 32'd1);
      d0 = done_cnt;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("reset_async_dut0", 32'(pack_act(0)), 32'd0);
      check("reset_async_dut1", 32'(pack_act(1)), 32'd0);
      cyc(3);
      rst_n = 1'b1;
      cyc(20);
      check("post_reset_idle", 32'(busy_o[0]), 32'd0);
      check("post_reset_no_done", 32'(done_cnt - d0), 32'd0);

      // Random pin activity, checked cycle by cycle against the model.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 2) == 0)  tick_i      = ~tick_i;
         if ($urandom_range(0, 59) == 0) start_btn_i = ~start_btn_i;
         if ($urandom_range(0, 29) == 0) react_btn_i = ~react_btn_i;
         cyc(1);
      end
      tick_i = 1'b0; start_btn_i = 1'b0; react_btn_i = 1'b0;
      cyc(10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
